// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: bit-serial loader for a configuration flip-flop chain.
// Words from a valid/ready stream are shifted MSB first into ccff_head,
// gated by config_enable.
// Optional readback with a CRC check is enabled by the macro
// CCFF_LOADER_READBACK_EN.
// Ports:
//   prog_clk, pReset_n                  clock, async active-low reset
//   start                               load request, sampled in IDLE
//   s_valid, s_ready, s_data            configuration word stream
//   ccff_head, config_enable, ccff_tail chain ends
//   busy, done, crc_err                 status
module ccff_chain_loader #(
    parameter int DATA_W    = 16,
    parameter int CHAIN_LEN = 64
) (
    input  logic              prog_clk,
    input  logic              pReset_n,
    input  logic              start,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              ccff_head,
    output logic              config_enable,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic              crc_err
);

    localparam int CW    = $clog2(CHAIN_LEN + 1);
    localparam int BW    = $clog2(DATA_W + 1);
    localparam int WORDS = (CHAIN_LEN + DATA_W - 1) / DATA_W;
    localparam int WW    = $clog2(WORDS + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOAD   = 2'd1;
    localparam logic [1:0] S_VERIFY = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] buf_q, buf_d;
    logic [BW-1:0]     bits_q, bits_d;
    logic [WW-1:0]     words_q, words_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              head_q, head_d;
    logic              en_q, en_d;

    logic in_load;
    logic last;
    logic xfer;
    logic shift;
    logic nbit;

    // A word may land while the final buffered bit is being consumed,
    // so ready is open with one bit left as well as when empty.
    always_comb begin
        in_load = (state_q == S_LOAD);
        last    = (cnt_q == CW'(CHAIN_LEN));
        s_ready = in_load
                && (bits_q <= BW'(1))
                && (words_q < WW'(WORDS));
        xfer    = s_valid && s_ready;
        shift   = in_load && !last
                && ((bits_q != '0) || xfer);
        // Empty buffer: take the MSB of the incoming word directly.
        nbit    = (bits_q != '0) ? buf_q[DATA_W-1]
                                 : s_data[DATA_W-1];
    end

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        bits_d  = bits_q;
        words_d = words_q;
        cnt_d   = cnt_q;
        head_d  = head_q;
        en_d    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    bits_d  = '0;
                    words_d = '0;
                    cnt_d   = '0;
                end
            end
            S_LOAD: begin
                if (shift) begin
                    head_d = nbit;
                    en_d   = 1'b1;
                    cnt_d  = cnt_q + CW'(1);
                end
                if (xfer) begin
                    words_d = words_q + WW'(1);
                    if (bits_q == '0) begin
                        buf_d  = s_data << 1;
                        bits_d = BW'(DATA_W - 1);
                    end else begin
                        buf_d  = s_data;
                        bits_d = BW'(DATA_W);
                    end
                end else if (shift) begin
                    buf_d  = buf_q << 1;
                    bits_d = bits_q - BW'(1);
                end
                // The last registered shift is on the chain this cycle;
                // leftover low bits of a partial word are dropped here.
                if (last) begin
                    cnt_d  = '0;
                    bits_d = '0;
`ifdef CCFF_LOADER_READBACK_EN
                    state_d = S_VERIFY;
`else
                    state_d = S_DONE;
`endif
                end
            end
            S_VERIFY: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(CHAIN_LEN - 1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            state_q <= S_IDLE;
            buf_q   <= '0;
            bits_q  <= '0;
            words_q <= '0;
            cnt_q   <= '0;
            head_q  <= 1'b0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            bits_q  <= bits_d;
            words_q <= words_d;
            cnt_q   <= cnt_d;
            head_q  <= head_d;
            en_q    <= en_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_DONE);

`ifdef CCFF_LOADER_READBACK_EN
    logic [15:0] crc_in_q, crc_in_d;
    logic [15:0] crc_out_q, crc_out_d;
    logic        err_q, err_d;
    logic        vfy;

    // CRC-16-CCITT, MSB-first, one bit per call.
    function automatic logic [15:0] crc_step(
        input logic [15:0] c,
        input logic        b
    );
        return {c[14:0], 1'b0}
             ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
    endfunction

    always_comb begin
        vfy       = (state_q == S_VERIFY);
        crc_in_d  = crc_in_q;
        crc_out_d = crc_out_q;
        err_d     = err_q;
        if ((state_q == S_IDLE) && start) begin
            crc_in_d  = 16'hFFFF;
            crc_out_d = 16'hFFFF;
            err_d     = 1'b0;
        end
        if (shift) begin
            crc_in_d = crc_step(crc_in_q, nbit);
        end
        if (vfy) begin
            crc_out_d = crc_step(crc_out_q, ccff_tail);
            if (cnt_q == CW'(CHAIN_LEN - 1)) begin
                err_d = (crc_in_q != crc_out_d);
            end
        end
    end

    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            crc_in_q  <= 16'hFFFF;
            crc_out_q <= 16'hFFFF;
            err_q     <= 1'b0;
        end else begin
            crc_in_q  <= crc_in_d;
            crc_out_q <= crc_out_d;
            err_q     <= err_d;
        end
    end

    // Recirculate tail to head so one full pass leaves the chain intact.
    assign ccff_head     = vfy ? ccff_tail : head_q;
    assign config_enable = en_q | vfy;
    assign crc_err       = err_q;
`else
    logic unused_tail;
    assign unused_tail   = ccff_tail;
    assign ccff_head     = head_q;
    assign config_enable = en_q;
    assign crc_err       = 1'b0;
`endif

endmodule

// File: tb/tb_ccff_chain_loader.sv
// tb_ccff_chain_loader: directed bench with chain models for a
// 32-bit and a 40-bit configuration chain.
module tb_ccff_chain_loader;

`ifdef CCFF_LOADER_READBACK_EN
    localparam int EN_A = 64;
    localparam int EN_B = 80;
`else
    localparam int EN_A = 32;
    localparam int EN_B = 40;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        a_start = 1'b0, a_valid = 1'b0;
    logic [15:0] a_data = '0;
    logic        a_ready, a_head, a_en, a_tail;
    logic        a_busy, a_done, a_err;
    logic        b_start = 1'b0, b_valid = 1'b0;
    logic [15:0] b_data = '0;
    logic        b_ready, b_head, b_en, b_tail;
    logic        b_busy, b_done, b_err;

    logic [31:0] chain_a;
    logic [39:0] chain_b;
    logic        flip = 1'b0;
    logic [15:0] bw [4];

    assign a_tail = chain_a[31];
    assign b_tail = chain_b[39];

    always @(posedge clk)
        chain_a <= (a_en ? {chain_a[30:0], a_head} : chain_a)
                 ^ (flip ? 32'h80 : 32'h0);

    always @(posedge clk)
        if (b_en) chain_b <= {chain_b[38:0], b_head};

    ccff_chain_loader #(.DATA_W(16), .CHAIN_LEN(32)) u_a (
        .prog_clk(clk), .pReset_n(rst_n), .start(a_start),
        .s_valid(a_valid), .s_ready(a_ready), .s_data(a_data),
        .ccff_head(a_head), .config_enable(a_en),
        .ccff_tail(a_tail), .busy(a_busy), .done(a_done),
        .crc_err(a_err)
    );

    ccff_chain_loader #(.DATA_W(16), .CHAIN_LEN(40)) u_b (
        .prog_clk(clk), .pReset_n(rst_n), .start(b_start),
        .s_valid(b_valid), .s_ready(b_ready), .s_data(b_data),
        .ccff_head(b_head), .config_enable(b_en),
        .ccff_tail(b_tail), .busy(b_busy), .done(b_done),
        .crc_err(b_err)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic expect_eq(
        input string       tag,
        input logic [63:0] got,
        input logic [63:0] exp
    );
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    int r_en, r_low, r_first, r_last, r_done, r_hbad, r_acc;
    logic r_edone, r_ex, r_rdy1, r_err1;
    logic [31:0] r_log;

    task automatic run_a(
        input logic [15:0] w0,
        input logic [15:0] w1,
        input int          gap,
        input int          rst_at,
        input bit          pulse,
        input bit          flp
    );
        int idx, hold, post;
        bit xfer, hdone;
        logic prev;
        r_en = 0; r_low = 0; r_first = -1; r_last = -1;
        r_done = 0; r_hbad = 0; r_acc = 0;
        r_edone = 1'b0; r_ex = 1'b0; r_log = '0;
        idx = 0; hold = 0; hdone = 0; post = 0;
        @(negedge clk);
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        r_rdy1 = a_ready;
        r_err1 = a_err;
        prev = a_head;
        for (int c = 0; c < 300 && post < 10; c++) begin
            if (gap > 0 && idx == 1 && a_ready && !hdone) begin
                hold = gap;
                hdone = 1;
            end
            if (hold > 0) begin
                a_valid = 1'b0;
                hold--;
            end else begin
                a_valid = (idx < 2);
            end
            a_data = (idx == 0) ? w0 : w1;
            a_start = pulse && a_busy && (c == 5 || c == 45);
            flip = flp && (r_en == 33);
            xfer = a_valid && a_ready;
            @(negedge clk);
            if (xfer) begin
                idx++;
                r_acc++;
                if (r_acc == 1) r_ex = a_en && (r_en == 0);
            end
            if (a_en) begin
                if (r_en < 32) r_log = {r_log[30:0], a_head};
                r_en++;
                if (r_first < 0) r_first = c;
                r_last = c;
            end else if (a_busy && r_en > 0 && r_en < 32) begin
                r_low++;
                if (a_head !== prev) r_hbad++;
            end
            prev = a_head;
            if (a_done) begin
                r_done++;
                r_edone = a_err;
            end
            if (r_done > 0) post++;
            if (rst_at > 0 && r_en == rst_at) begin
                #2 rst_n = 1'b0;
                #1;
                expect_eq("rst_async_outs",
                    {a_ready, a_head, a_en, a_busy, a_done, a_err},
                    6'b0);
                a_valid = 1'b0;
                a_start = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                break;
            end
        end
        a_valid = 1'b0;
        a_start = 1'b0;
        flip = 1'b0;
    endtask

    int rb_en, rb_acc, rb_extra, rb_done;
    logic rb_err;

    task automatic run_b();
        int idx, post;
        bit xfer;
        rb_en = 0; rb_extra = 0; rb_done = 0; rb_err = 1'b0;
        idx = 0; post = 0;
        @(negedge clk);
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        for (int c = 0; c < 300 && post < 10; c++) begin
            b_valid = (idx < 4);
            b_data = bw[idx[1:0]];
            if (b_ready && idx >= 3) rb_extra++;
            xfer = b_valid && b_ready;
            @(negedge clk);
            if (xfer) idx++;
            if (b_en) rb_en++;
            if (b_done) begin
                rb_done++;
                rb_err = b_err;
            end
            if (rb_done > 0) post++;
        end
        rb_acc = idx;
        b_valid = 1'b0;
    endtask

    initial begin
        bw = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};
        repeat (3) @(negedge clk);
        expect_eq("reset_outs_a",
            {a_ready, a_head, a_en, a_busy, a_done, a_err}, 6'b0);
        expect_eq("reset_outs_b",
            {b_ready, b_head, b_en, b_busy, b_done, b_err}, 6'b0);
        rst_n = 1'b1;
        @(negedge clk);
        expect_eq("idle_outs_a",
            {a_ready, a_en, a_busy, a_done}, 4'b0);

        run_a(16'hA5C3, 16'h0FF0, 0, 0, 0, 0);
        expect_eq("basic_ready_after_start", r_rdy1, 1);
        expect_eq("basic_en_after_xfer", r_ex, 1);
        expect_eq("basic_en_count", r_en, EN_A);
        expect_eq("basic_en_span", r_last - r_first + 1, EN_A);
        expect_eq("basic_stall_cycles", r_low, 0);
        expect_eq("basic_head_seq", r_log, 32'hA5C30FF0);
        expect_eq("basic_chain", chain_a, 32'hA5C30FF0);
        expect_eq("basic_words", r_acc, 2);
        expect_eq("basic_done", r_done, 1);
        expect_eq("basic_crc_err", r_edone, 0);

        run_a(16'h8001, 16'h7FFE, 6, 0, 0, 0);
        expect_eq("stall_en_count", r_en, EN_A);
        expect_eq("stall_low_cycles", r_low, 5);
        expect_eq("stall_head_hold", r_hbad, 0);
        expect_eq("stall_en_span", r_last - r_first + 1, EN_A + 5);
        expect_eq("stall_chain", chain_a, 32'h80017FFE);
        expect_eq("stall_done", r_done, 1);

`ifdef CCFF_LOADER_READBACK_EN
        run_a(16'hA5C3, 16'h0FF0, 0, 0, 0, 1);
        expect_eq("flip_done", r_done, 1);
        expect_eq("flip_crc_err", r_edone, 1);
        expect_eq("flip_crc_err_held", a_err, 1);
`endif

        run_a(16'h1357, 16'h2468, 0, 10, 0, 0);
        expect_eq("rst_no_done", r_done, 0);
        expect_eq("rst_idle", {a_busy, a_en, a_ready}, 3'b0);
        run_a(16'h1357, 16'h2468, 0, 0, 0, 0);
        expect_eq("after_rst_err_clr", r_err1, 0);
        expect_eq("after_rst_chain", chain_a, 32'h13572468);
        expect_eq("after_rst_done", r_done, 1);
        expect_eq("after_rst_crc_err", r_edone, 0);

        run_a(16'hFFFF, 16'h0001, 0, 0, 1, 0);
        expect_eq("start_ign_done", r_done, 1);
        expect_eq("start_ign_en", r_en, EN_A);
        expect_eq("start_ign_span", r_last - r_first + 1, EN_A);
        expect_eq("start_ign_chain", chain_a, 32'hFFFF0001);
        expect_eq("start_ign_words", r_acc, 2);

        run_b();
        expect_eq("part_words", rb_acc, 3);
        expect_eq("part_extra_ready", rb_extra, 0);
        expect_eq("part_en_count", rb_en, EN_B);
        expect_eq("part_chain", chain_b, 40'h123456789A);
        expect_eq("part_done", rb_done, 1);
        expect_eq("part_crc_err", rb_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule
